// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: DMA state encoding, register addresses and
// the GET/PUT meaning of the bus-cycle parity bit.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] ADDR_DMA_REG  = 16'h4014;
  localparam logic [15:0] ADDR_OAM_DATA = 16'h2004;

  localparam logic PARITY_GET = 1'b0;
  localparam logic PARITY_PUT = 1'b1;

endpackage

// File: rtl/dma_cycle_parity.sv
// Free-running bus-cycle parity flop: toggles once per CPU bus cycle so DMA
// engines can tell GET (0) cycles from PUT (1) cycles.
module dma_cycle_parity (
  input  logic clk,
  input  logic rst,
  input  logic ph2_falling,
  output logic parity
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (ph2_falling) begin
      parity <= ~parity;
    end
  end

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA bus master: a CPU write of page P to the DMA register halts the
// CPU and copies $PP00-$PPFF into OAM through repeated writes to OAM data.
module oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAM_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1_rising,
  input  logic        ph1_falling,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_dout,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic        mst_active,
  output logic [15:0] mst_addr,
  output logic        mst_rnw,
  output logic [7:0]  mst_dout,
  input  logic [7:0]  mst_din
);

  dma_state_t  state, state_next;
  logic [7:0]  page, page_next;
  logic [7:0]  idx, idx_next;
  logic [15:0] addr_next;
  logic [7:0]  dout_next;
  logic        parity;
  logic        trigger;

  // Only ph2_falling matters here; the other phase strobes are part of the
  // shared port set but carry no information for this engine.
  logic unused_strobes;
  assign unused_strobes = ^{ph1_rising, ph1_falling, ph2_rising};

  dma_cycle_parity u_parity (
    .clk         (clk),
    .rst         (rst),
    .ph2_falling (ph2_falling),
    .parity      (parity)
  );

  assign cpu_halt   = (state != IDLE);
  assign dma_busy   = (state != IDLE);
  assign mst_active = (state == READ) || (state == WRITE);
  assign mst_rnw    = (state != WRITE);
  assign trigger    = (cpu_addr == DMA_REG_ADDR) && !cpu_rnw && !mst_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      mst_addr <= 16'h0000;
      mst_dout <= 8'h00;
    end else begin
      state    <= state_next;
      page     <= page_next;
      idx      <= idx_next;
      mst_addr <= addr_next;
      mst_dout <= dout_next;
    end
  end

  // The master address is loaded for the upcoming state so it is stable for
  // the whole bus cycle; the read byte is latched straight into mst_dout.
  always_comb begin
    state_next = state;
    page_next  = page;
    idx_next   = idx;
    addr_next  = mst_addr;
    dout_next  = mst_dout;
    if (ph2_falling) begin
      case (state)
        IDLE: begin
          if (trigger) begin
            page_next  = cpu_dout;
            idx_next   = 8'h00;
            state_next = HALT;
          end
        end
        HALT: begin
          // The CPU only stalls on a read; parity flips at this same edge.
          if (cpu_rnw) begin
            if (~parity == PARITY_PUT) begin
              state_next = ALIGN;
            end else begin
              state_next = READ;
              addr_next  = {page, idx};
            end
          end
        end
        ALIGN: begin
          state_next = READ;
          addr_next  = {page, idx};
        end
        READ: begin
          dout_next  = mst_din;
          state_next = WRITE;
          addr_next  = OAM_DATA_ADDR;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx + 8'd1;
            state_next = READ;
            addr_next  = {page, idx + 8'd1};
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
